// File: rtl/hazard_pkg.sv
// Shared encodings for the multi-cycle hazard controller: forwarding classes,
// opcode and branch-outcome constants, and the stall FSM state type.
package hazard_pkg;

    localparam logic [1:0] NO_FW          = 2'b00;
    localparam logic [1:0] WB_FW          = 2'b01;
    localparam logic [1:0] MEM_FW         = 2'b10;
    localparam logic [6:0] OPC_LOAD       = 7'b0000011;
    localparam logic [1:0] BR_NO_REDIRECT = 2'b01;
    localparam int         LU_CNT_W       = 3;

    typedef enum logic [0:0] {
        RUN      = 1'b0,
        LU_STALL = 1'b1
    } hz_state_t;

endpackage

// File: rtl/hazard_ctrl_mc_sat_counter.sv
// Saturating event counter: counts inc pulses and sticks at all-ones.
module sat_counter #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 inc,
    output logic [CNT_WIDTH-1:0] count
);

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

    logic [CNT_WIDTH-1:0] count_r;

    // Count register with saturation at the maximum value.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= {CNT_WIDTH{1'b0}};
        end else if (inc && (count_r != CNT_MAX)) begin
            count_r <= count_r + CNT_ONE;
        end else begin
            count_r <= count_r;
        end
    end

    assign count = count_r;

endmodule

// File: rtl/hazard_ctrl_mc.sv
// Multi-cycle hazard/stall controller for the 5-stage pipeline: load-use
// bubbles, data-memory wait freeze, branch redirect flush and perf counters.
module hazard_ctrl_mc
    import hazard_pkg::*;
#(
    parameter int WIDTH_DATA_LENGTH = 32,
    parameter int LU_STALL_CYCLES   = 1,
    parameter int BR_FLUSH_STAGES   = 1,
    parameter int CNT_WIDTH         = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [WIDTH_DATA_LENGTH-1:0] Inst_EX,
    input  logic [1:0]                   Fw_Detected,
    input  logic                         Br_Detected,
    input  logic [1:0]                   Br_result,
    input  logic                         Dmem_Req,
    input  logic                         Dmem_Ready,
    output logic                         PC_Fetch_EN,
    output logic                         FE_DE_Reg_EN,
    output logic                         DE_EX_Reg_EN,
    output logic                         EX_MEM_Reg_EN,
    output logic                         FE_DE_Reg_RST,
    output logic                         DE_EX_Reg_RST,
    output logic                         EX_MEM_Reg_RST,
    output logic                         MEM_WB_Reg_RST,
    output logic                         Stall_Detected,
    output logic [CNT_WIDTH-1:0]         Stall_Cnt,
    output logic [CNT_WIDTH-1:0]         Flush_Cnt
);

    localparam logic [LU_CNT_W-1:0] LU_RELOAD = LU_CNT_W'(LU_STALL_CYCLES - 1);
    localparam logic [LU_CNT_W-1:0] LU_ONE    = {{(LU_CNT_W-1){1'b0}}, 1'b1};

    hz_state_t           state_r, state_nxt_s;
    logic [LU_CNT_W-1:0] bub_cnt_r, bub_cnt_nxt_s;

    logic load_s, lu_hazard_s, mem_wait_s, redirect_s;
    logic pc_en_s, fe_de_en_s, de_ex_en_s, ex_mem_en_s;
    logic fe_de_rst_s, de_ex_rst_s, ex_mem_rst_s, mem_wb_rst_s;
    logic stall_s, flush_evt_s;
    logic unused_inst_s;

    assign load_s        = (Inst_EX[6:0] == OPC_LOAD);
    assign lu_hazard_s   = load_s && (Fw_Detected == MEM_FW);
    assign mem_wait_s    = Dmem_Req && !Dmem_Ready;
    assign redirect_s    = Br_Detected && (Br_result != BR_NO_REDIRECT);
    assign unused_inst_s = ^Inst_EX[WIDTH_DATA_LENGTH-1:7];

    // FSM state and bubble counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= RUN;
            bub_cnt_r <= {LU_CNT_W{1'b0}};
        end else begin
            state_r   <= state_nxt_s;
            bub_cnt_r <= bub_cnt_nxt_s;
        end
    end

    // Next-state and control-output decode; mem_wait outranks load-use, which outranks redirect.
    always_comb begin
        state_nxt_s   = state_r;
        bub_cnt_nxt_s = bub_cnt_r;
        pc_en_s       = 1'b1;
        fe_de_en_s    = 1'b1;
        de_ex_en_s    = 1'b1;
        ex_mem_en_s   = 1'b1;
        fe_de_rst_s   = 1'b0;
        de_ex_rst_s   = 1'b0;
        ex_mem_rst_s  = 1'b0;
        mem_wb_rst_s  = 1'b0;
        stall_s       = 1'b0;
        flush_evt_s   = 1'b0;
        if (rst) begin
            state_nxt_s   = RUN;
            bub_cnt_nxt_s = {LU_CNT_W{1'b0}};
        end else if (mem_wait_s) begin
            pc_en_s      = 1'b0;
            fe_de_en_s   = 1'b0;
            de_ex_en_s   = 1'b0;
            ex_mem_en_s  = 1'b0;
            mem_wb_rst_s = 1'b1;
            stall_s      = 1'b1;
        end else begin
            case (state_r)
                LU_STALL: begin
                    pc_en_s       = 1'b0;
                    fe_de_en_s    = 1'b0;
                    de_ex_en_s    = 1'b0;
                    ex_mem_rst_s  = 1'b1;
                    stall_s       = 1'b1;
                    bub_cnt_nxt_s = bub_cnt_r - LU_ONE;
                    if (bub_cnt_r == LU_ONE) begin
                        state_nxt_s = RUN;
                    end else begin
                        state_nxt_s = LU_STALL;
                    end
                end
                RUN: begin
                    if (lu_hazard_s) begin
                        pc_en_s      = 1'b0;
                        fe_de_en_s   = 1'b0;
                        de_ex_en_s   = 1'b0;
                        ex_mem_rst_s = 1'b1;
                        stall_s      = 1'b1;
                        if (LU_STALL_CYCLES > 1) begin
                            state_nxt_s   = LU_STALL;
                            bub_cnt_nxt_s = LU_RELOAD;
                        end else begin
                            state_nxt_s = RUN;
                        end
                    end else if (redirect_s) begin
                        de_ex_rst_s = 1'b1;
                        fe_de_rst_s = (BR_FLUSH_STAGES == 2);
                        flush_evt_s = 1'b1;
                    end else begin
                        state_nxt_s = RUN;
                    end
                end
                default: begin
                    state_nxt_s   = RUN;
                    bub_cnt_nxt_s = {LU_CNT_W{1'b0}};
                end
            endcase
        end
    end

    assign PC_Fetch_EN    = pc_en_s;
    assign FE_DE_Reg_EN   = fe_de_en_s;
    assign DE_EX_Reg_EN   = de_ex_en_s;
    assign EX_MEM_Reg_EN  = ex_mem_en_s;
    assign FE_DE_Reg_RST  = fe_de_rst_s;
    assign DE_EX_Reg_RST  = de_ex_rst_s;
    assign EX_MEM_Reg_RST = ex_mem_rst_s;
    assign MEM_WB_Reg_RST = mem_wb_rst_s;
    assign Stall_Detected = stall_s;

    sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (stall_s),
        .count (Stall_Cnt)
    );

    sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (flush_evt_s),
        .count (Flush_Cnt)
    );

endmodule

// File: tb/tb_hazard_ctrl_mc.sv
// Directed bench for hazard_ctrl_mc: a vector table on one configuration plus
// hand sequences for multi-bubble stalls, two-stage flush and saturation.
module tb_hazard_ctrl_mc;

    typedef struct packed {
        logic        rst;
        logic [31:0] inst;
        logic [1:0]  fw;
        logic        br;
        logic [1:0]  brres;
        logic        req;
        logic        rdy;
    } in_t;

    typedef struct packed {
        in_t         vin;
        logic [8:0]  ctrl;
        logic [15:0] sc;
        logic [15:0] fc;
    } vec_t;

    // ctrl = {PC_EN, FE_DE_EN, DE_EX_EN, EX_MEM_EN, FE_DE_RST, DE_EX_RST, EX_MEM_RST, MEM_WB_RST, STALL}
    localparam logic [8:0] C_IDLE = 9'b111100000;
    localparam logic [8:0] C_LU   = 9'b000100101;
    localparam logic [8:0] C_FRZ  = 9'b000000011;
    localparam logic [8:0] C_BR1  = 9'b111101000;
    localparam logic [8:0] C_BR2  = 9'b111111000;
    localparam logic [31:0] LW    = 32'h00012083;
    localparam logic [31:0] ADD   = 32'h00000033;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    in_t in_a, in_b, in_c;
    wire [8:0]  ctrl_a, ctrl_b, ctrl_c;
    wire [15:0] sc_a, fc_a, sc_b, fc_b;
    wire [3:0]  sc_c, fc_c;

    int n_vec  = 0;
    int n_fail = 0;

    hazard_ctrl_mc #(.LU_STALL_CYCLES(1), .BR_FLUSH_STAGES(1), .CNT_WIDTH(16)) dut_a (
        .clk(clk), .rst(in_a.rst), .Inst_EX(in_a.inst), .Fw_Detected(in_a.fw),
        .Br_Detected(in_a.br), .Br_result(in_a.brres), .Dmem_Req(in_a.req), .Dmem_Ready(in_a.rdy),
        .PC_Fetch_EN(ctrl_a[8]), .FE_DE_Reg_EN(ctrl_a[7]), .DE_EX_Reg_EN(ctrl_a[6]),
        .EX_MEM_Reg_EN(ctrl_a[5]), .FE_DE_Reg_RST(ctrl_a[4]), .DE_EX_Reg_RST(ctrl_a[3]),
        .EX_MEM_Reg_RST(ctrl_a[2]), .MEM_WB_Reg_RST(ctrl_a[1]), .Stall_Detected(ctrl_a[0]),
        .Stall_Cnt(sc_a), .Flush_Cnt(fc_a));

    hazard_ctrl_mc #(.LU_STALL_CYCLES(3), .BR_FLUSH_STAGES(2), .CNT_WIDTH(16)) dut_b (
        .clk(clk), .rst(in_b.rst), .Inst_EX(in_b.inst), .Fw_Detected(in_b.fw),
        .Br_Detected(in_b.br), .Br_result(in_b.brres), .Dmem_Req(in_b.req), .Dmem_Ready(in_b.rdy),
        .PC_Fetch_EN(ctrl_b[8]), .FE_DE_Reg_EN(ctrl_b[7]), .DE_EX_Reg_EN(ctrl_b[6]),
        .EX_MEM_Reg_EN(ctrl_b[5]), .FE_DE_Reg_RST(ctrl_b[4]), .DE_EX_Reg_RST(ctrl_b[3]),
        .EX_MEM_Reg_RST(ctrl_b[2]), .MEM_WB_Reg_RST(ctrl_b[1]), .Stall_Detected(ctrl_b[0]),
        .Stall_Cnt(sc_b), .Flush_Cnt(fc_b));

    hazard_ctrl_mc #(.LU_STALL_CYCLES(1), .BR_FLUSH_STAGES(1), .CNT_WIDTH(4)) dut_c (
        .clk(clk), .rst(in_c.rst), .Inst_EX(in_c.inst), .Fw_Detected(in_c.fw),
        .Br_Detected(in_c.br), .Br_result(in_c.brres), .Dmem_Req(in_c.req), .Dmem_Ready(in_c.rdy),
        .PC_Fetch_EN(ctrl_c[8]), .FE_DE_Reg_EN(ctrl_c[7]), .DE_EX_Reg_EN(ctrl_c[6]),
        .EX_MEM_Reg_EN(ctrl_c[5]), .FE_DE_Reg_RST(ctrl_c[4]), .DE_EX_Reg_RST(ctrl_c[3]),
        .EX_MEM_Reg_RST(ctrl_c[2]), .MEM_WB_Reg_RST(ctrl_c[1]), .Stall_Detected(ctrl_c[0]),
        .Stall_Cnt(sc_c), .Flush_Cnt(fc_c));

    function automatic in_t mk(logic r, logic [31:0] i, logic [1:0] f, logic b,
                               logic [1:0] bres, logic rq, logic rd);
        in_t t;
        t.rst = r; t.inst = i; t.fw = f; t.br = b; t.brres = bres; t.req = rq; t.rdy = rd;
        return t;
    endfunction

    function automatic vec_t v(in_t i, logic [8:0] c, logic [15:0] s, logic [15:0] f);
        vec_t t;
        t.vin = i; t.ctrl = c; t.sc = s; t.fc = f;
        return t;
    endfunction

    task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    vec_t tbl [17];
    in_t  nop;

    initial begin
        nop  = mk(1'b0, ADD, 2'b00, 1'b0, 2'b01, 1'b0, 1'b1);
        in_a = mk(1'b1, ADD, 2'b00, 1'b0, 2'b01, 1'b0, 1'b1);
        in_b = in_a;
        in_c = in_a;

        tbl[0]  = v(mk(1'b1, LW,  2'b10, 1'b0, 2'b01, 1'b0, 1'b1), C_IDLE, 16'd0, 16'd0);
        tbl[1]  = v(nop,                                             C_IDLE, 16'd0, 16'd0);
        tbl[2]  = v(mk(1'b0, LW,  2'b10, 1'b0, 2'b01, 1'b0, 1'b1), C_LU,   16'd0, 16'd0);
        tbl[3]  = v(mk(1'b0, LW,  2'b01, 1'b0, 2'b01, 1'b0, 1'b1), C_IDLE, 16'd1, 16'd0);
        tbl[4]  = v(mk(1'b0, ADD, 2'b10, 1'b0, 2'b01, 1'b0, 1'b1), C_IDLE, 16'd1, 16'd0);
        tbl[5]  = v(mk(1'b0, ADD, 2'b00, 1'b0, 2'b01, 1'b1, 1'b0), C_FRZ,  16'd1, 16'd0);
        tbl[6]  = v(mk(1'b0, ADD, 2'b00, 1'b0, 2'b01, 1'b1, 1'b1), C_IDLE, 16'd2, 16'd0);
        tbl[7]  = v(mk(1'b0, ADD, 2'b00, 1'b1, 2'b10, 1'b0, 1'b1), C_BR1,  16'd2, 16'd0);
        tbl[8]  = v(mk(1'b0, ADD, 2'b00, 1'b1, 2'b01, 1'b0, 1'b1), C_IDLE, 16'd2, 16'd1);
        tbl[9]  = v(mk(1'b0, ADD, 2'b00, 1'b1, 2'b11, 1'b0, 1'b1), C_BR1,  16'd2, 16'd1);
        tbl[10] = v(mk(1'b0, ADD, 2'b00, 1'b1, 2'b00, 1'b1, 1'b0), C_FRZ,  16'd2, 16'd2);
        tbl[11] = v(mk(1'b0, ADD, 2'b00, 1'b1, 2'b00, 1'b0, 1'b1), C_BR1,  16'd3, 16'd2);
        tbl[12] = v(mk(1'b0, LW,  2'b10, 1'b1, 2'b10, 1'b0, 1'b1), C_LU,   16'd3, 16'd3);
        tbl[13] = v(mk(1'b0, LW,  2'b10, 1'b0, 2'b01, 1'b1, 1'b0), C_FRZ,  16'd4, 16'd3);
        tbl[14] = v(nop,                                             C_IDLE, 16'd5, 16'd3);
        tbl[15] = v(mk(1'b1, ADD, 2'b00, 1'b0, 2'b01, 1'b0, 1'b1), C_IDLE, 16'd5, 16'd3);
        tbl[16] = v(nop,                                             C_IDLE, 16'd0, 16'd0);

        repeat (2) @(posedge clk);

        // Table-driven run on configuration A (1 bubble, 1-stage flush).
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            in_a = tbl[i].vin;
            #1;
            chk($sformatf("a_v%0d_ctrl", i), {23'd0, ctrl_a}, {23'd0, tbl[i].ctrl});
            chk($sformatf("a_v%0d_stall_cnt", i), {16'd0, sc_a}, {16'd0, tbl[i].sc});
            chk($sformatf("a_v%0d_flush_cnt", i), {16'd0, fc_a}, {16'd0, tbl[i].fc});
        end

        // Configuration B: 3-bubble load-use, freeze inside bubbles, 2-stage flush, reset mid-stall.
        @(negedge clk); in_b = nop; #1;
        chk("b_reset_ctrl", {23'd0, ctrl_b}, {23'd0, C_IDLE});
        chk("b_reset_sc", {16'd0, sc_b}, 32'd0);
        @(negedge clk); in_b = mk(1'b0, LW, 2'b10, 1'b0, 2'b01, 1'b0, 1'b1); #1;
        chk("b_lu_bubble1", {23'd0, ctrl_b}, {23'd0, C_LU});
        @(negedge clk); in_b = nop; #1;
        chk("b_lu_bubble2", {23'd0, ctrl_b}, {23'd0, C_LU});
        @(negedge clk); #1;
        chk("b_lu_bubble3", {23'd0, ctrl_b}, {23'd0, C_LU});
        @(negedge clk); #1;
        chk("b_lu_done", {23'd0, ctrl_b}, {23'd0, C_IDLE});
        chk("b_lu_sc3", {16'd0, sc_b}, 32'd3);
        @(negedge clk); in_b = mk(1'b0, LW, 2'b10, 1'b0, 2'b01, 1'b0, 1'b1); #1;
        chk("b_w_bubble1", {23'd0, ctrl_b}, {23'd0, C_LU});
        @(negedge clk); in_b = mk(1'b0, ADD, 2'b00, 1'b0, 2'b01, 1'b1, 1'b0); #1;
        chk("b_w_freeze1", {23'd0, ctrl_b}, {23'd0, C_FRZ});
        @(negedge clk); #1;
        chk("b_w_freeze2", {23'd0, ctrl_b}, {23'd0, C_FRZ});
        @(negedge clk); in_b = nop; #1;
        chk("b_w_bubble2", {23'd0, ctrl_b}, {23'd0, C_LU});
        @(negedge clk); #1;
        chk("b_w_bubble3", {23'd0, ctrl_b}, {23'd0, C_LU});
        @(negedge clk); #1;
        chk("b_w_done", {23'd0, ctrl_b}, {23'd0, C_IDLE});
        chk("b_w_sc8", {16'd0, sc_b}, 32'd8);
        @(negedge clk); in_b = mk(1'b0, ADD, 2'b00, 1'b1, 2'b10, 1'b0, 1'b1); #1;
        chk("b_br2_flush", {23'd0, ctrl_b}, {23'd0, C_BR2});
        @(negedge clk); in_b = nop; #1;
        chk("b_br2_after", {23'd0, ctrl_b}, {23'd0, C_IDLE});
        chk("b_br2_fc1", {16'd0, fc_b}, 32'd1);
        @(negedge clk); in_b = mk(1'b0, LW, 2'b10, 1'b0, 2'b01, 1'b0, 1'b1); #1;
        chk("b_rst_bubble1", {23'd0, ctrl_b}, {23'd0, C_LU});
        @(negedge clk); in_b = mk(1'b1, ADD, 2'b00, 1'b0, 2'b01, 1'b0, 1'b1); #1;
        chk("b_rst_forced_idle", {23'd0, ctrl_b}, {23'd0, C_IDLE});
        @(negedge clk); in_b = nop; #1;
        chk("b_rst_after_ctrl", {23'd0, ctrl_b}, {23'd0, C_IDLE});
        chk("b_rst_after_sc", {16'd0, sc_b}, 32'd0);
        chk("b_rst_after_fc", {16'd0, fc_b}, 32'd0);

        // Configuration C: 4-bit counter saturates under continuous load-use.
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            in_c = mk(1'b0, LW, 2'b10, 1'b0, 2'b01, 1'b0, 1'b1);
            #1;
            chk($sformatf("c_sat_cycle%0d", i), {28'd0, sc_c}, (i > 15) ? 32'd15 : i);
        end
        @(negedge clk); in_c = nop; #1;
        chk("c_sat_hold", {28'd0, sc_c}, 32'd15);
        @(negedge clk); in_c = mk(1'b1, ADD, 2'b00, 1'b0, 2'b01, 1'b0, 1'b1);
        @(negedge clk); in_c = nop; #1;
        chk("c_rst_sc", {28'd0, sc_c}, 32'd0);
        chk("c_rst_ctrl", {23'd0, ctrl_c}, {23'd0, C_IDLE});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
